// File: rtl/io_map_pkg.sv
// Shared IO-map constants: word-address select bits, status bit positions and
// the UART serializer state encoding.
package io_map_pkg;

  localparam int IO_LEDS_BIT      = 0;
  localparam int IO_UART_DAT_BIT  = 1;
  localparam int IO_UART_STAT_BIT = 2;

  localparam int ST_EMPTY       = 0;
  localparam int ST_FULL        = 1;
  localparam int ST_BUSY        = 2;
  localparam int ST_OVF         = 3;
  localparam int ST_LEGACY_BUSY = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 transmitter: takes one byte when idle and shifts it out LSB first,
// holding each symbol for DIV clock cycles. tx is a registered output.
module uart_tx_serializer
  import io_map_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  uart_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid) begin
            shift_q <= data;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              // Present the next bit while shifting it down into position 0.
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q != S_IDLE);
  assign tx    = tx_q;

endmodule

// File: rtl/io_responder.sv
// IO bus target: one-hot word-address decode for the LED register, UART data
// and UART status, plus the TX FIFO feeding the serializer.
module io_responder
  import io_map_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8,
  parameter int LED_WIDTH   = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          IO_mem_addr,
  input  logic [31:0]          IO_mem_wdata,
  input  logic                 IO_mem_wr,
  output logic [31:0]          IO_mem_rdata,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 uart_tx
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  logic [13:0] word_addr;
  logic        sel_led, sel_dat, sel_stat;
  assign word_addr = IO_mem_addr[15:2];
  assign sel_led   = word_addr[IO_LEDS_BIT];
  assign sel_dat   = word_addr[IO_UART_DAT_BIT];
  assign sel_stat  = word_addr[IO_UART_STAT_BIT];

  logic [7:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 ovf_q;
  logic [LED_WIDTH-1:0] leds_q;

  logic fifo_empty, fifo_full, push_req, push_ok, pop;
  logic ser_ready, ser_busy;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign push_req   = IO_mem_wr && sel_dat;
  assign pop        = !fifo_empty && ser_ready;
  // A full FIFO still accepts a push when the serializer drains it the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= IO_mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      leds_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (IO_mem_wr && sel_stat) ovf_q <= 1'b0;
      if (push_req && !push_ok)  ovf_q <= 1'b1;
      if (IO_mem_wr && sel_led)  leds_q <= IO_mem_wdata[LED_WIDTH-1:0];
    end
  end

  uart_tx_serializer #(.DIV(DIV)) u_ser (
    .clk    (clk),
    .resetn (resetn),
    .valid  (!fifo_empty),
    .data   (fifo_mem[rd_ptr_q]),
    .ready  (ser_ready),
    .busy   (ser_busy),
    .tx     (uart_tx)
  );

  logic [31:0] status;
  always_comb begin
    status                 = '0;
    status[ST_EMPTY]       = fifo_empty;
    status[ST_FULL]        = fifo_full;
    status[ST_BUSY]        = ser_busy;
    status[ST_OVF]         = ovf_q;
    status[ST_LEGACY_BUSY] = fifo_full;
  end

  // UART data reads as zero, so only LED and status contribute to the OR.
  always_comb begin
    IO_mem_rdata = '0;
    if (sel_led)  IO_mem_rdata = IO_mem_rdata | {{(32-LED_WIDTH){1'b0}}, leds_q};
    if (sel_stat) IO_mem_rdata = IO_mem_rdata | status;
  end

  assign leds = leds_q;

  logic unused_bits;
  assign unused_bits = ^{IO_mem_addr[31:16], IO_mem_addr[1:0], word_addr[13:3], IO_mem_wdata};

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder with DIV=4 and a 4-entry FIFO.
module tb_io_responder;

  localparam logic [31:0] A_NONE = 32'h0040_0000;
  localparam logic [31:0] A_LED  = 32'h0040_0004;
  localparam logic [31:0] A_DAT  = 32'h0040_0008;
  localparam logic [31:0] A_STAT = 32'h0040_0010;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic [31:0] rdata;
  logic [5:0]  leds;
  logic        tx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_responder #(
    .CLK_FREQ_HZ (4),
    .BAUD        (1),
    .FIFO_DEPTH  (4),
    .LED_WIDTH   (6)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .IO_mem_addr  (addr),
    .IO_mem_wdata (wdata),
    .IO_mem_wr    (wr),
    .IO_mem_rdata (rdata),
    .leds         (leds),
    .uart_tx      (tx)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr_io(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    step();
    wr    = 1'b0;
    addr  = '0;
    $display("write addr=0x%08h data=0x%08h", a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
    addr = '0;
  endtask

  // Checks one 10-symbol frame from sample index skip onward (4 samples per symbol).
  task automatic frame_chk(input string tag, input logic [7:0] b, input int skip);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = skip; i < 40; i++) begin
      chk($sformatf("%s_sym%0d", tag, i / 4), {31'b0, tx}, {31'b0, fr[i / 4]});
      step();
    end
    $display("frame %s byte=0x%02h checked", tag, b);
  endtask

  initial begin
    logic [7:0] ovf_bytes [6];
    ovf_bytes[0] = 8'hA5; ovf_bytes[1] = 8'h3C; ovf_bytes[2] = 8'h0F;
    ovf_bytes[3] = 8'hF0; ovf_bytes[4] = 8'h81; ovf_bytes[5] = 8'h7E;

    // Reset state
    resetn = 1'b0;
    step(2);
    chk("rst_leds", {26'b0, leds}, 32'h0);
    chk("rst_tx", {31'b0, tx}, 32'h1);
    rd_chk("rst_status", A_STAT, 32'h001);
    resetn = 1'b1;
    step();

    // LED register, decode and OR-combined reads
    wr_io(A_LED, 32'hFFFF_FFAA);
    chk("led_val", {26'b0, leds}, 32'h2A);
    rd_chk("led_read", A_LED, 32'h0000_002A);
    rd_chk("dat_read", A_DAT, 32'h0);
    rd_chk("none_read", A_NONE, 32'h0);
    rd_chk("multi_read", 32'h0040_0014, 32'h0000_002B);
    wr_io(A_NONE, 32'h15);
    chk("none_write_ignored", {26'b0, leds}, 32'h2A);

    // Single byte, exact start latency and busy flag
    wr_io(A_DAT, 32'h55);
    chk("b55_idle_before", {31'b0, tx}, 32'h1);
    rd_chk("b55_status_queued", A_STAT, 32'h000);
    step();
    rd_chk("b55_status_busy", A_STAT, 32'h005);
    frame_chk("b55", 8'h55, 0);
    chk("b55_idle_after", {31'b0, tx}, 32'h1);
    rd_chk("b55_status_after", A_STAT, 32'h001);
    step(3);

    // Overflow: first byte pops at once, four fill the FIFO, the sixth is dropped
    for (int i = 0; i < 6; i++) wr_io(A_DAT, {24'h0, ovf_bytes[i]});
    rd_chk("ovf_status_full", A_STAT, 32'h20E);
    wr_io(A_STAT, 32'h0);
    rd_chk("ovf_status_cleared", A_STAT, 32'h206);
    frame_chk("ovf0", ovf_bytes[0], 5);
    for (int f = 1; f < 5; f++) begin
      chk($sformatf("ovf_gap%0d", f), {31'b0, tx}, 32'h1);
      step();
      frame_chk($sformatf("ovf%0d", f), ovf_bytes[f], 0);
    end
    rd_chk("ovf_status_done", A_STAT, 32'h001);
    for (int i = 0; i < 12; i++) begin
      chk("ovf_no_sixth_frame", {31'b0, tx}, 32'h1);
      step();
    end

    // Back-to-back frames with one idle cycle between them
    wr_io(A_DAT, 32'h01);
    wr_io(A_DAT, 32'h80);
    rd_chk("b2b_status", A_STAT, 32'h004);
    frame_chk("b2b_01", 8'h01, 0);
    chk("b2b_gap", {31'b0, tx}, 32'h1);
    step();
    frame_chk("b2b_80", 8'h80, 0);
    rd_chk("b2b_status_after", A_STAT, 32'h001);
    step(2);

    // Reset during data bit 3 with one byte still queued
    wr_io(A_DAT, 32'hC3);
    wr_io(A_DAT, 32'h99);
    chk("mid_start", {31'b0, tx}, 32'h0);
    step(17);
    chk("mid_bit3", {31'b0, tx}, 32'h0);
    rd_chk("mid_status_busy", A_STAT, 32'h004);
    resetn = 1'b0;
    step();
    chk("mid_rst_tx", {31'b0, tx}, 32'h1);
    chk("mid_rst_leds", {26'b0, leds}, 32'h0);
    rd_chk("mid_rst_status", A_STAT, 32'h001);
    resetn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("mid_no_frame", {31'b0, tx}, 32'h1);
    end
    rd_chk("mid_final_status", A_STAT, 32'h001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
